plastic_neuron_array: RTL and testbench

Parametrised multi-synapse successor of the single-weight plastic neuron. Accepts a vector of `N_IN` signed inputs plus one signed error term. It computes the dot product with its `N_IN` per-synapse weights using one time-multiplexed MAC over `N_IN` cycles. In the same pass it applies the sign-based Hebbian update to each weight, saturating at the signed weight limits. It sits between the input feature stage and downstream neuron layers, and uses valid/ready on both sides.

---
 rtl/plastic_pkg.sv | 12 +
 rtl/hebbian_update.sv | 28 ++
 rtl/plastic_neuron_array.sv | 94 +++++++++
 tb/tb_plastic_neuron_array.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/plastic_pkg.sv
// plastic_pkg: FSM state, weight saturation limits and default learning parameters shared by the neuron array
package plastic_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int W_INIT_DEF = 1030;
    localparam int LEARN_RATE_DEF = 32;
    function automatic longint w_max(input int ww);
        return (longint'(1) <<< (ww - 1)) - 1;
    endfunction
    function automatic longint w_min(input int ww);
        return -(longint'(1) <<< (ww - 1));
    endfunction
endpackage

// File: rtl/hebbian_update.sv
// hebbian_update: sign-based Hebbian step for one weight, saturating to the signed weight range
module hebbian_update
    import plastic_pkg::*;
#(
    parameter int WEIGHT_W = 16,
    parameter int LEARN_RATE = LEARN_RATE_DEF
)(
    input  logic signed [WEIGHT_W-1:0] w,
    input  logic                       x_pos,
    input  logic                       err_pos,
    input  logic                       err_neg,
    input  logic                       learn_en,
    output logic signed [WEIGHT_W-1:0] w_next,
    output logic                       clamped
);
    localparam logic signed [WEIGHT_W+1:0] MAX = (WEIGHT_W+2)'(w_max(WEIGHT_W));
    localparam logic signed [WEIGHT_W+1:0] MIN = (WEIGHT_W+2)'(w_min(WEIGHT_W));
    localparam logic signed [WEIGHT_W+1:0] STEP = (WEIGHT_W+2)'(LEARN_RATE);
    logic up, dn;
    logic signed [WEIGHT_W+1:0] sum;
    always_comb begin
        up = learn_en & x_pos & err_pos;
        dn = learn_en & x_pos & err_neg;
        sum = (WEIGHT_W+2)'(w) + (up ? STEP : dn ? -STEP : '0);
        clamped = sum > MAX || sum < MIN;
        w_next = sum > MAX ? MAX[WEIGHT_W-1:0] : sum < MIN ? MIN[WEIGHT_W-1:0] : sum[WEIGHT_W-1:0];
    end
endmodule

// File: rtl/plastic_neuron_array.sv
// plastic_neuron_array: N_IN-synapse neuron, one time-multiplexed MAC with in-pass Hebbian weight learning
module plastic_neuron_array
    import plastic_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int DATA_W = 16,
    parameter int WEIGHT_W = 16,
    parameter int LEARN_RATE = LEARN_RATE_DEF,
    parameter int W_INIT = W_INIT_DEF,
    localparam int ACC_W = DATA_W + WEIGHT_W + $clog2(N_IN),
    localparam int IDX_W = $clog2(N_IN)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DATA_W-1:0]     in_data,
    input  logic signed [DATA_W-1:0]   in_err,
    input  logic                       learn_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic signed [WEIGHT_W-1:0] wr_data,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic signed [WEIGHT_W-1:0] rd_data,
    output logic                       w_sat
);
    localparam int PW = DATA_W + WEIGHT_W;
    state_t state;
    logic [IDX_W-1:0] idx;
    logic [N_IN*DATA_W-1:0] x_reg;
    logic signed [DATA_W-1:0] err_reg, x_cur;
    logic learn_reg, clamped, wr_ok;
    logic signed [WEIGHT_W-1:0] w [N_IN];
    logic signed [WEIGHT_W-1:0] w_cur, w_next;
    logic signed [PW-1:0] prod;

    assign in_ready = state == IDLE && !rst;
    assign out_valid = state == DONE;
    assign wr_ok = {1'b0, wr_idx} < (IDX_W+1)'(N_IN);
    assign rd_data = {1'b0, rd_idx} < (IDX_W+1)'(N_IN) ? w[rd_idx] : '0;
    assign x_cur = x_reg[idx*DATA_W +: DATA_W];
    assign w_cur = w[idx];
    assign prod = PW'(x_cur) * PW'(w_cur);

    hebbian_update #(.WEIGHT_W(WEIGHT_W), .LEARN_RATE(LEARN_RATE)) u_hebb (
        .w(w_cur),
        .x_pos(!x_cur[DATA_W-1] && x_cur != '0),
        .err_pos(!err_reg[DATA_W-1] && err_reg != '0),
        .err_neg(err_reg[DATA_W-1]),
        .learn_en(learn_reg),
        .w_next(w_next),
        .clamped(clamped)
    );

    // out_data doubles as the accumulator; it is only presented as valid in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            x_reg <= '0;
            err_reg <= '0;
            learn_reg <= 1'b0;
            out_data <= '0;
            w_sat <= 1'b0;
            for (int i = 0; i < N_IN; i++) w[i] <= WEIGHT_W'(W_INIT);
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en && wr_ok) w[wr_idx] <= wr_data;
                    if (in_valid) begin
                        state <= RUN;
                        idx <= '0;
                        x_reg <= in_data;
                        err_reg <= in_err;
                        learn_reg <= learn_en;
                        out_data <= '0;
                    end
                end
                RUN: begin
                    out_data <= out_data + ACC_W'(prod);
                    w[idx] <= w_next;
                    w_sat <= w_sat | clamped;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_IN - 1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plastic_neuron_array.sv
// tb_plastic_neuron_array: directed vectors with a result scoreboard drained by a handshake monitor
module tb_plastic_neuron_array;
    localparam int N_IN = 8, DW = 16, WW = 16, ACC_W = DW + WW + $clog2(N_IN);
    logic clk = 0, rst = 0, in_valid = 0, learn_en = 0, out_ready = 1, wr_en = 0;
    logic in_ready, out_valid, w_sat;
    logic [N_IN*DW-1:0] in_data = '0;
    logic signed [DW-1:0] in_err = '0;
    logic signed [ACC_W-1:0] out_data;
    logic [2:0] wr_idx = '0, rd_idx = '0;
    logic signed [WW-1:0] wr_data = '0, rd_data;
    int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    logic seen = 0;
    longint exp_q[$];

    plastic_neuron_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_err(in_err), .learn_en(learn_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .w_sat(w_sat)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input int i, input longint exp);
        rd_idx = 3'(i);
        #1;
        chk($sformatf("w%0d", i), rd_data, exp);
    endtask

    function automatic logic [N_IN*DW-1:0] vec(input int v[N_IN]);
        logic [N_IN*DW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'(v[i]);
        return r;
    endfunction

    function automatic logic [N_IN*DW-1:0] vec_u(input int a);
        logic [N_IN*DW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'(a);
        return r;
    endfunction

    task automatic send(input logic [N_IN*DW-1:0] d, input int e, input logic l, input longint exp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", in_ready, 1);
        exp_q.push_back(exp);
        in_data = d;
        in_err = DW'(e);
        learn_en = l;
        in_valid = 1;
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w_sat", w_sat, 0);
        chk("rst_out_data", out_data, 0);
        for (int i = 0; i < N_IN; i++) chk_w(i, 1030);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                #2;
                if (out_valid && !seen) chk("latency", cyc - acc_cyc, N_IN);
                seen = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got %0d, required no output", out_data);
                    end else chk("out_data", out_data, exp_q.pop_front());
                end
            end
        join_none
        do_reset();
        send(vec_u(1), 0, 0, 8240);
        wait_done();
        chk_w(0, 1030);
        chk_w(7, 1030);
        send(vec_u(2), 5, 1, 16480);
        wait_done();
        chk_w(0, 1062);
        chk_w(7, 1062);
        send(vec_u(2), 5, 1, 16992);
        wait_done();
        chk_w(4, 1094);
        do_reset();
        send(vec('{3, -3, 0, 0, 0, 0, 0, 0}), -1, 1, 0);
        wait_done();
        chk_w(0, 998);
        chk_w(1, 1030);
        chk_w(2, 1030);
        wr_en = 1;
        wr_idx = 2;
        wr_data = 16'sd32760;
        @(negedge clk);
        wr_en = 0;
        chk_w(2, 32760);
        send(vec('{0, 0, 1, 0, 0, 0, 0, 0}), 1, 1, 32760);
        wait_done();
        chk_w(2, 32767);
        chk("w_sat_set", w_sat, 1);
        send(vec('{0, 0, 1, 0, 0, 0, 0, 0}), 1, 1, 32767);
        wait_done();
        chk_w(2, 32767);
        wr_en = 1;
        wr_idx = 3;
        wr_data = 16'sd100;
        send(vec('{0, 0, 0, 1, 0, 0, 0, 0}), 0, 1, 100);
        wr_en = 0;
        wait_done();
        chk_w(3, 100);
        out_ready = 0;
        send(vec_u(1), 0, 0, 39015);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_en = i == 5;
            wr_idx = 0;
            wr_data = 16'sd5;
            chk("bp_out_data", out_data, 39015);
            chk("bp_in_ready", in_ready, 0);
        end
        wr_en = 0;
        chk_w(0, 998);
        out_ready = 1;
        wait_done();
        chk("release_in_ready", in_ready, 1);
        in_data = vec_u(2);
        in_err = 16'sd5;
        learn_en = 1;
        in_valid = 1;
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        chk_w(1, 1062);
        chk_w(3, 100);
        do_reset();
        send(vec_u(1), 0, 0, 8240);
        wait_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
